// File: rtl/pipe_stage_hs_pkg.sv
// Shared pipeline-bundle definitions: field widths, NOP encoding, control struct
// and the handshake stage occupancy states.
package pipe_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_W    = 32;
   localparam int unsigned CTRL_W  = 16;
   localparam int unsigned STAGE_W = INSTR_W + PC_W + CTRL_W;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic       reg_we;
      logic       mem_rd;
      logic       mem_wr;
      logic       branch;
      logic       jump;
      logic [3:0] alu_op;
      logic [6:0] rsvd;
   } ctrl_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
      ctrl_t              ctrl;
   } stage_t;

   // Bubble bundle: NOP instruction with all control strobes inactive.
   localparam stage_t NOP_BUNDLE = '{instr: NOP_INSTR, pc: '0, ctrl: '0};

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ONE,
      ST_FULL
   } stage_state_e;

endpackage

// File: rtl/pipe_stage_hs.sv
// Generic valid/ready pipeline stage register with optional 2-entry skid buffer,
// synchronous flush with bubble insertion and a saturating stall counter.
module pipe_stage_hs
   import pipe_pkg::*;
#(
   parameter int unsigned        DATA_W     = STAGE_W,
   parameter int unsigned        SKID       = 1,
   parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
   parameter int unsigned        CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   stage_state_e      state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d, skid_q;
   logic              main_load, skid_load;
   logic              accept, emit;

   assign accept = in_valid & in_ready;
   assign emit   = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else if (SKID != 0) begin
         case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
               if (accept && !emit)      state_d = ST_FULL;
               else if (emit && !accept) state_d = ST_EMPTY;
            end
            ST_FULL:  if (emit) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
         endcase
      end else begin
         if (accept)    state_d = ST_ONE;
         else if (emit) state_d = ST_EMPTY;
      end
   end

   // in_ready in skid mode depends on registered state only.
   always_comb begin
      out_valid = (state_q != ST_EMPTY);
      out_data  = out_valid ? main_q : BUBBLE_VAL;
      if (SKID != 0) in_ready = (state_q != ST_FULL);
      else           in_ready = (state_q == ST_EMPTY) || out_ready;
   end

   // Without a skid entry, an accept in ONE implies an emit, so the same
   // load rules cover both configurations.
   always_comb begin
      main_load = 1'b0;
      skid_load = 1'b0;
      main_d    = main_q;
      if (!flush) begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_load = 1'b1;
                  main_d    = in_data;
               end
            end
            ST_ONE: begin
               if (accept && emit) begin
                  main_load = 1'b1;
                  main_d    = in_data;
               end else if (accept) begin
                  skid_load = 1'b1;
               end
            end
            ST_FULL: begin
               if (emit) begin
                  main_load = 1'b1;
                  main_d    = skid_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            main_q <= '0;
      else if (main_load) main_q <= main_d;
   end

   generate
      if (SKID != 0) begin : g_skid
         always_ff @(posedge clk or posedge rst) begin
            if (rst)            skid_q <= '0;
            else if (skid_load) skid_q <= in_data;
         end
      end else begin : g_noskid
         assign skid_q = '0;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench for pipe_stage_hs: skid, non-skid and narrow-counter instances
// driven with shared stimulus and checked against queue-based occupancy models.
module tb_pipe_stage_hs;
   import pipe_pkg::*;

   localparam int unsigned W    = STAGE_W;
   localparam logic [W-1:0] BUB1 = NOP_BUNDLE;
   localparam logic [W-1:0] BUB0 = '0;
   localparam int unsigned SAT16 = 65535;
   localparam int unsigned SAT4  = 15;

   logic         clk = 1'b0, rst = 1'b1, flush = 1'b0;
   logic         in_valid = 1'b0, out_ready = 1'b0;
   logic [W-1:0] in_data = '0;

   logic         ir1, ov1, ir0, ov0, irs, ovs;
   logic [W-1:0] od1, od0, ods;
   logic [15:0]  sc1, sc0;
   logic [3:0]   scs;

   int checks = 0, failures = 0;
   logic [W-1:0] q1[$], q0[$];
   int unsigned  st1 = 0, st0 = 0, sts = 0;

   pipe_stage_hs #(.DATA_W(W), .SKID(1), .BUBBLE_VAL(BUB1), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
      .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
      .stall_cnt(sc1));

   pipe_stage_hs #(.DATA_W(W), .SKID(0), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
      .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
      .stall_cnt(sc0));

   pipe_stage_hs #(.DATA_W(W), .SKID(1), .BUBBLE_VAL(BUB1), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(irs),
      .in_data(in_data), .out_valid(ovs), .out_ready(out_ready), .out_data(ods),
      .stall_cnt(scs));

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rnd();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[W-1:0];
   endfunction

   // Monitor: consumes expected entries whenever a DUT transfers downstream.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (ov1) begin
               if (q1.size() == 0) chk("mon1_spurious", ov1, 1'b0);
               else begin
                  chk("mon1_data", od1, q1[0]);
                  chk("mons_data", ods, q1[0]);
                  if (out_ready) void'(q1.pop_front());
               end
            end else begin
               chk("bubble1", od1, BUB1);
               chk("bubbles", ods, BUB1);
            end
            if (ov0) begin
               if (q0.size() == 0) chk("mon0_spurious", ov0, 1'b0);
               else begin
                  chk("mon0_data", od0, q0[0]);
                  if (out_ready) void'(q0.pop_front());
               end
            end else begin
               chk("bubble0", od0, BUB0);
            end
         end
      end
   end

   // One cycle of stimulus; the model decides acceptance from queue occupancy.
   task automatic drive(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
      bit ir1_prev, m1_rdy, m0_rdy, a1, a0;
      @(negedge clk);
      ir1_prev  = ir1;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      #1;
      chk("ir1_no_comb_path", ir1, ir1_prev);
      m1_rdy = (q1.size() < 2);
      m0_rdy = (q0.size() == 0) || ordy;
      chk("in_ready1", ir1, m1_rdy);
      chk("in_readys", irs, m1_rdy);
      chk("in_ready0", ir0, m0_rdy);
      chk("out_valid1", ov1, q1.size() != 0);
      chk("out_valids", ovs, q1.size() != 0);
      chk("out_valid0", ov0, q0.size() != 0);
      chk("stall1", sc1, st1);
      chk("stalls", scs, sts);
      chk("stall0", sc0, st0);
      if (q1.size() != 0 && !ordy) begin
         if (st1 < SAT16) st1++;
         if (sts < SAT4)  sts++;
      end
      if (q0.size() != 0 && !ordy && st0 < SAT16) st0++;
      a1 = iv && m1_rdy;
      a0 = iv && m0_rdy;
      #2;
      if (fl) begin
         q1.delete();
         q0.delete();
      end else begin
         if (a1) q1.push_back(d);
         if (a0) q0.push_back(d);
      end
   endtask

   initial begin
      #1;
      chk("rst_out_valid1", ov1, 1'b0);
      chk("rst_out_data1", od1, BUB1);
      chk("rst_in_ready1", ir1, 1'b1);
      chk("rst_in_ready0", ir0, 1'b1);
      chk("rst_stall1", sc1, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Streaming
      for (int i = 1; i <= 8; i++) drive(1'b1, W'(i), 1'b1, 1'b0);
      repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

      // Back-pressure
      drive(1'b1, W'('hA), 1'b0, 1'b0);
      drive(1'b1, W'('hB), 1'b0, 1'b0);
      drive(1'b1, W'('hC), 1'b0, 1'b0);
      drive(1'b1, W'('hC), 1'b0, 1'b0);
      drive(1'b1, W'('hC), 1'b1, 1'b0);
      drive(1'b1, W'('hC), 1'b1, 1'b0);
      repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

      // Flush while FULL, while ONE (accept discarded), and with an emit
      drive(1'b1, W'('h11), 1'b0, 1'b0);
      drive(1'b1, W'('h12), 1'b0, 1'b0);
      drive(1'b1, W'('h13), 1'b0, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b0);
      drive(1'b1, W'('h21), 1'b0, 1'b0);
      drive(1'b1, W'('h22), 1'b0, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b0);
      drive(1'b1, W'('h31), 1'b1, 1'b0);
      drive(1'b1, W'('h32), 1'b1, 1'b1);
      repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

      // Asynchronous reset with data held
      drive(1'b1, rnd(), 1'b0, 1'b0);
      drive(1'b1, rnd(), 1'b0, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk("arst_out_valid1", ov1, 1'b0);
      chk("arst_out_data1", od1, BUB1);
      chk("arst_in_ready1", ir1, 1'b1);
      chk("arst_stall1", sc1, '0);
      chk("arst_out_valid0", ov0, 1'b0);
      chk("arst_out_data0", od0, BUB0);
      chk("arst_out_datas", ods, BUB1);
      chk("arst_stalls", scs, '0);
      q1.delete();
      q0.delete();
      st1 = 0; st0 = 0; sts = 0;
      in_valid = 1'b0;
      flush = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Saturation of the 4-bit counter
      drive(1'b1, W'('h55), 1'b0, 1'b0);
      repeat (20) drive(1'b0, '0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("sat_stalls", scs, W'(15));
      drive(1'b0, '0, 1'b1, 1'b0);

      // Random traffic
      repeat (10000)
         drive($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 9) < 7,
               $urandom_range(0, 31) == 0);
      repeat (4) drive(1'b0, '0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
